sobel_row_feeder: RTL and testbench
===================================

Name: sobel_row_feeder

Overview:
- Source end of the sobel column array: accepts a raster pixel stream (valid/ready) and assembles COLS pixels into one image row.
- Presents each completed row in parallel to the array as per-column current/left/right pixel buses, with one-cycle row strobes.
- Replicates image borders: left/right edge columns, top row at frame start, bottom row at frame end.
- Sits between the frame/pixel source and the array of per-column sobel elements; row_valid is their advance enable.

Parameters:
- COLS, 8, number of columns (pixels per row); legal range 4..64.
- PIX_W, 8, pixel width in bits.
- FLUSH_ROWS, 2, bottom-border replicas of the last row emitted after end of frame; legal range 1..3.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_pixel  in  PIX_W  incoming pixel, raster order.
- s_valid  in  1  s_pixel valid.
- s_sof  in  1  first pixel of frame; qualified by s_valid.
- s_eof  in  1  last pixel of frame; qualified by s_valid.
- s_ready  out  1  feeder can accept; a transfer occurs when s_valid && s_ready.
- row_cur  out  COLS*PIX_W  pixel of column c at bits [c*PIX_W +: PIX_W].
- row_left  out  COLS*PIX_W  left neighbour of column c; column 0 carries its own pixel.
- row_right  out  COLS*PIX_W  right neighbour of column c; column COLS-1 carries its own pixel.
- row_valid  out  1  one-cycle strobe per emitted row.
- row_first  out  1  high with row_valid on the top-border replica.
- row_last  out  1  high with row_valid on the final flush replica.
- busy  out  1  high in any state other than IDLE.
- frame_err  out  1  sticky protocol error flag; cleared only on an accepted s_sof.

Behaviour:
- Reset (asynchronous, rst_n low):
  - row_cur/left/right = 0; row_valid, row_first, row_last, busy, frame_err = 0.
  - col = 0; state = IDLE; s_ready = 1.
- States: IDLE, FILL, FLUSH.
- Storage: a fill buffer (COLS pixels) and separate output registers. Output registers change only on a row emit.
- IDLE:
  - Transfers without s_sof are accepted and discarded.
  - A transfer with s_sof writes fill[0], sets col = 1, clears frame_err, goes to FILL, and arms the top replica.
- FILL:
  - Each transfer writes fill[col] and increments col.
  - On the transfer at col == COLS-1, the row is complete: output registers load {fill[0..COLS-2], s_pixel}, and row_valid = 1 on the next cycle (latency 1).
  - First row of a frame: row_valid is high for 2 consecutive cycles with the same data, row_first = 1 on the first of them only.
  - s_ready stays 1 throughout FILL. COLS >= 4 guarantees the replica ends before the next row completes.
- End of frame (s_eof):
  - s_eof on the transfer at col == COLS-1 completes the row normally, then enters FLUSH.
  - s_eof with col < COLS-1: the remaining columns are padded with that pixel, the row is emitted, frame_err is set, then FLUSH.
  - s_eof together with s_sof (single-pixel frame): pad the whole row, top replica, then FLUSH; frame_err is set.
- s_sof in FILL:
  - The partial row is discarded, frame_err is set, and the pixel is taken as fill[0] of a new frame (col = 1, top replica re-armed).
  - The clear of frame_err is suppressed for this case; the set wins.
- FLUSH:
  - s_ready = 0.
  - Re-emits the output registers FLUSH_ROWS times on consecutive cycles, starting the cycle after the last normal or top emission completes.
  - row_last = 1 on the final replica; then return to IDLE.
- Neighbour buses: pure wiring of the output registers, so they are always coherent with row_cur and need no extra cycle.
- Reset mid-frame or mid-FLUSH: immediate return to reset values; no partial strobe is ever emitted.

Decomposition:
- Shared package holds:
  - PIX_W default;
  - state encoding (IDLE = 2'd0, FILL = 2'd1, FLUSH = 2'd2);
  - a row-slice helper function (column index -> bit offset), shared with the array top.
- One natural sub-module: sobel_row_neighbours, the combinational left/right bus generator with edge replication, reusable by the array top for its debug taps.

Test Plan:
Benches run with COLS=4, PIX_W=8, FLUSH_ROWS=2.
- Reset: rst_n low mid-FILL -> all outputs 0 and s_ready=1 within the same cycle; first transfer after release without s_sof is discarded.
- Single clean frame, 2 rows (10,20,30,40 / 50,60,70,80, eof on 80):
  - Row 1: row_valid for 2 cycles, first with row_first; row_cur = {40,30,20,10}, row_left = {30,20,10,10}, row_right = {40,40,30,20}.
  - Row 2: emitted once.
  - Flush: 2 replicas of row 2, second with row_last; s_ready=0 during FLUSH; then busy=0.
- Back-pressure-free gaps: s_valid toggled every other cycle -> identical emitted data; each row_valid 1 cycle after its 4th pixel.
- Short row: eof on 3rd pixel (1,2,3) -> row_cur = {3,3,2,1}, frame_err=1, flush follows.
- Sof mid-row after 2 pixels -> frame_err=1, no emission for the partial row; new frame's first row gets a top replica.
- Single-pixel frame (sof+eof, pixel 9) -> 4 strobes total, all rows {9,9,9,9}, row_first on strobe 1, row_last on strobe 4, frame_err=1.

Source files
------------

// File: rtl/sobel_row_feeder_pkg.sv
// rtl/sobel_row_feeder_pkg.sv - shared types and helpers for the sobel row feeder
// Holds the default pixel width, the feeder state encoding and the
// column-to-bit-offset helper used wherever a packed row bus is sliced.
package sobel_row_feeder_pkg;

   localparam int PIX_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      FLUSH = 2'd2
   } feeder_state_t;

   // Bit offset of column c inside a packed row of w-bit pixels.
   function automatic int col_off(input int c, input int w);
      return c * w;
   endfunction

endpackage

// File: rtl/sobel_row_neighbours.sv
// rtl/sobel_row_neighbours.sv - left/right neighbour buses with edge replication
// Ports:
//   row_cur   in  packed row, column c at [c*PIX_W +: PIX_W]
//   row_left  out left neighbour per column, column 0 repeats itself
//   row_right out right neighbour per column, column COLS-1 repeats itself
module sobel_row_neighbours
   import sobel_row_feeder_pkg::*;
#(
   parameter int COLS  = 8,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic [COLS*PIX_W-1:0] row_cur,
   output logic [COLS*PIX_W-1:0] row_left,
   output logic [COLS*PIX_W-1:0] row_right
);

   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int LC = (c == 0) ? 0 : c - 1;
      localparam int RC = (c == COLS - 1) ? COLS - 1 : c + 1;
      assign row_left[col_off(c, PIX_W) +: PIX_W]  = row_cur[col_off(LC, PIX_W) +: PIX_W];
      assign row_right[col_off(c, PIX_W) +: PIX_W] = row_cur[col_off(RC, PIX_W) +: PIX_W];
   end

endmodule

// File: rtl/sobel_row_feeder.sv
// rtl/sobel_row_feeder.sv - raster pixel stream to parallel row feeder for the sobel array
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_pixel/s_valid/s_ready    raster pixel stream, s_sof/s_eof frame markers
//   row_cur/row_left/row_right packed row and its neighbour buses
//   row_valid                  one-cycle strobe per emitted row (array advance)
//   row_first/row_last         top-border replica / final bottom-border replica
//   busy                       feeder not idle
//   frame_err                  sticky protocol error, cleared by an accepted s_sof
module sobel_row_feeder
   import sobel_row_feeder_pkg::*;
#(
   parameter int COLS       = 8,
   parameter int PIX_W      = PIX_W_DEF,
   parameter int FLUSH_ROWS = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [PIX_W-1:0]       s_pixel,
   input  logic                   s_valid,
   input  logic                   s_sof,
   input  logic                   s_eof,
   output logic                   s_ready,
   output logic [COLS*PIX_W-1:0]  row_cur,
   output logic [COLS*PIX_W-1:0]  row_left,
   output logic [COLS*PIX_W-1:0]  row_right,
   output logic                   row_valid,
   output logic                   row_first,
   output logic                   row_last,
   output logic                   busy,
   output logic                   frame_err
);

   localparam int          CW        = $clog2(COLS);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
   localparam logic [1:0]  FLUSH_CNT = 2'(FLUSH_ROWS);

   feeder_state_t     state;
   logic [CW-1:0]     col;
   logic              armed;      // next completed row is the first of its frame
   logic              rep_pend;   // top-border replica due next cycle
   logic [1:0]        flush_cnt;
   // The last column never needs storing: it arrives with the completing transfer.
   logic [PIX_W-1:0]  fill [COLS-1];

   logic              xfer;
   logic              take;
   logic              done;
   logic              armed_eff;
   logic              err_next;
   logic [CW-1:0]     ec;

   assign s_ready = (state != FLUSH);
   assign busy    = (state != IDLE);

   always_comb begin
      xfer      = s_valid && s_ready;
      take      = xfer && (s_sof || state == FILL);
      ec        = s_sof ? '0 : col;
      armed_eff = s_sof || armed;
      done      = take && (s_eof || ec == LAST_COL);
      err_next  = frame_err;
      // An s_sof inside an open frame is itself an error, so it never clears the flag.
      if (xfer && s_sof)
         err_next = (state == FILL);
      if (take && s_eof && ec != LAST_COL)
         err_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (take && !done)
         fill[ec] <= s_pixel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         col       <= '0;
         armed     <= 1'b0;
         rep_pend  <= 1'b0;
         flush_cnt <= '0;
         row_cur   <= '0;
         row_valid <= 1'b0;
         row_first <= 1'b0;
         row_last  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         row_valid <= 1'b0;
         row_first <= 1'b0;
         row_last  <= 1'b0;
         frame_err <= err_next;
         case (state)
            IDLE, FILL: begin
               if (rep_pend) begin
                  row_valid <= 1'b1;
                  rep_pend  <= 1'b0;
               end
               if (take) begin
                  if (s_sof)
                     armed <= 1'b1;
                  if (done) begin
                     // Columns at or beyond the completing one take s_pixel,
                     // which both completes a full row and pads a short one.
                     for (int c = 0; c < COLS - 1; c++)
                        row_cur[col_off(c, PIX_W) +: PIX_W] <= (c < int'(ec)) ? fill[c] : s_pixel;
                     row_cur[col_off(COLS - 1, PIX_W) +: PIX_W] <= s_pixel;
                     row_valid <= 1'b1;
                     row_first <= armed_eff;
                     rep_pend  <= armed_eff;
                     armed     <= 1'b0;
                     col       <= '0;
                     if (s_eof) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_CNT;
                     end else begin
                        state <= FILL;
                     end
                  end else begin
                     col   <= ec + CW'(1);
                     state <= FILL;
                  end
               end
            end
            FLUSH: begin
               if (rep_pend) begin
                  row_valid <= 1'b1;
                  rep_pend  <= 1'b0;
               end else if (flush_cnt != 2'd0) begin
                  row_valid <= 1'b1;
                  row_last  <= (flush_cnt == 2'd1);
                  flush_cnt <= flush_cnt - 2'd1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sobel_row_neighbours #(
      .COLS  (COLS),
      .PIX_W (PIX_W)
   ) u_neighbours (
      .row_cur   (row_cur),
      .row_left  (row_left),
      .row_right (row_right)
   );

endmodule

// File: tb/tb_sobel_row_feeder.sv
// tb/tb_sobel_row_feeder.sv - self-checking bench for sobel_row_feeder
module tb_sobel_row_feeder;

   localparam int COLS  = 4;
   localparam int PIX_W = 8;
   localparam int FR    = 2;
   localparam int W     = COLS * PIX_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [PIX_W-1:0] s_pixel = '0;
   logic             s_valid = 1'b0;
   logic             s_sof = 1'b0;
   logic             s_eof = 1'b0;
   logic             s_ready;
   logic [W-1:0]     row_cur, row_left, row_right;
   logic             row_valid, row_first, row_last, busy, frame_err;

   sobel_row_feeder #(.COLS(COLS), .PIX_W(PIX_W), .FLUSH_ROWS(FR)) dut (
      .clk(clk), .rst_n(rst_n), .s_pixel(s_pixel), .s_valid(s_valid),
      .s_sof(s_sof), .s_eof(s_eof), .s_ready(s_ready), .row_cur(row_cur),
      .row_left(row_left), .row_right(row_right), .row_valid(row_valid),
      .row_first(row_first), .row_last(row_last), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      logic [W-1:0] cur;
      logic [W-1:0] left;
      logic [W-1:0] right;
      logic         first;
      logic         last;
   } strobe_t;

   strobe_t      exp_q[$];
   int           n_chk = 0;
   int           n_bad = 0;
   int           ecnt = 0;
   int           cur_q[$];
   bit           frame_open = 0;
   bit           armed = 0;
   bit           m_err = 0;
   int           flush_from = -1;
   int           flush_to = -1;
   logic [W-1:0] last_cur = '0, last_left = '0, last_right = '0;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, ecnt);
      end
   endtask

   function automatic strobe_t mk(input int cyc, input int px[COLS], input bit f, input bit l);
      strobe_t s;
      s.cyc = cyc; s.first = f; s.last = l;
      s.cur = '0; s.left = '0; s.right = '0;
      for (int c = 0; c < COLS; c++) begin
         s.cur[c*PIX_W +: PIX_W]   = PIX_W'(px[c]);
         s.left[c*PIX_W +: PIX_W]  = PIX_W'(px[(c == 0) ? 0 : c - 1]);
         s.right[c*PIX_W +: PIX_W] = PIX_W'(px[(c == COLS - 1) ? COLS - 1 : c + 1]);
      end
      return s;
   endfunction

   function automatic bit flushing(input int e);
      return (e >= flush_from) && (e < flush_to);
   endfunction

   // Row-level model: a transfer accepted on edge e emits its row after edge e,
   // a frame's first row is shown twice, and after end of frame FR replicas follow
   // back to back; input is refused from the eof edge until one edge past the last replica.
   task automatic model_xfer(input int e, input int p, input bit sof, input bit eof);
      int k;
      int px[COLS];
      if (sof) begin
         m_err = frame_open;
         cur_q.delete();
         armed = 1;
         frame_open = 1;
      end else if (!frame_open) begin
         return;
      end
      cur_q.push_back(p);
      if (eof || cur_q.size() == COLS) begin
         k = e;
         if (cur_q.size() < COLS) m_err = 1;
         while (cur_q.size() < COLS) cur_q.push_back(p);
         for (int c = 0; c < COLS; c++) px[c] = cur_q[c];
         exp_q.push_back(mk(e, px, armed, 0));
         if (armed) begin
            k = e + 1;
            exp_q.push_back(mk(k, px, 0, 0));
         end
         armed = 0;
         cur_q.delete();
         if (eof) begin
            for (int i = 1; i <= FR; i++) exp_q.push_back(mk(k + i, px, 0, i == FR));
            flush_from = e;
            flush_to = k + FR + 1;
            frame_open = 0;
         end
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      cur_q.delete();
      frame_open = 0; armed = 0; m_err = 0;
      flush_from = -1; flush_to = -1;
      last_cur = '0; last_left = '0; last_right = '0;
   endtask

   // Called at a falling edge: check the current cycle, then drive the next edge.
   task automatic cycle(input bit v, input int p, input bit sof, input bit eof);
      bit      ev;
      strobe_t s;
      s.first = 0; s.last = 0;
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == ecnt);
      if (ev) begin
         s = exp_q.pop_front();
         last_cur = s.cur; last_left = s.left; last_right = s.right;
      end
      check_eq("row_valid", W'(row_valid), W'(ev));
      check_eq("row_first", W'(row_first), W'(ev && s.first));
      check_eq("row_last", W'(row_last), W'(ev && s.last));
      check_eq("row_cur", row_cur, last_cur);
      check_eq("row_left", row_left, last_left);
      check_eq("row_right", row_right, last_right);
      check_eq("s_ready", W'(s_ready), W'(!flushing(ecnt)));
      check_eq("busy", W'(busy), W'(frame_open || flushing(ecnt)));
      check_eq("frame_err", W'(frame_err), W'(m_err));
      s_valid = v; s_pixel = PIX_W'(p); s_sof = sof; s_eof = eof;
      if (v && rst_n && !flushing(ecnt)) model_xfer(ecnt + 1, p, sof, eof);
      @(posedge clk);
      ecnt++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   initial begin
      bit v, sof, eof;
      int p;
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Clean two-row frame with explicit first-row values.
      cycle(1, 10, 1, 0); cycle(1, 20, 0, 0); cycle(1, 30, 0, 0); cycle(1, 40, 0, 0);
      check_eq("t1_first_valid", W'(row_valid), W'(1));
      check_eq("t1_first_flag", W'(row_first), W'(1));
      check_eq("t1_cur", row_cur, 32'h281e140a);
      check_eq("t1_left", row_left, 32'h1e140a0a);
      check_eq("t1_right", row_right, 32'h28281e14);
      cycle(1, 50, 0, 0); cycle(1, 60, 0, 0); cycle(1, 70, 0, 0); cycle(1, 80, 0, 1);
      cycle(1, 99, 0, 0); cycle(1, 98, 0, 0);
      idle(4);

      // Same frame with gaps on s_valid.
      for (int i = 0; i < 8; i++) begin
         cycle(1, 10 * (i + 1), i == 0, i == 7);
         cycle(0, 0, 0, 0);
      end
      idle(4);

      // Short row padded by eof.
      cycle(1, 1, 1, 0); cycle(1, 2, 0, 0); cycle(1, 3, 0, 1);
      check_eq("t3_cur", row_cur, 32'h03030201);
      check_eq("t3_err", W'(frame_err), W'(1));
      idle(6);

      // s_sof mid-row, then a complete frame.
      cycle(1, 5, 1, 0); cycle(1, 6, 0, 0); cycle(1, 7, 1, 0);
      check_eq("t4_err", W'(frame_err), W'(1));
      cycle(1, 8, 0, 0); cycle(1, 9, 0, 0); cycle(1, 10, 0, 0);
      cycle(1, 11, 0, 0); cycle(1, 12, 0, 0); cycle(1, 13, 0, 0); cycle(1, 14, 0, 1);
      idle(6);

      // Single-pixel frame.
      cycle(1, 9, 1, 1);
      check_eq("t5_cur", row_cur, 32'h09090909);
      idle(6);

      // Asynchronous reset in the middle of a row.
      cycle(1, 33, 1, 0); cycle(1, 34, 0, 0);
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_valid", W'(row_valid), W'(0));
      check_eq("rst_ready", W'(s_ready), W'(1));
      check_eq("rst_busy", W'(busy), W'(0));
      check_eq("rst_cur", row_cur, '0);
      check_eq("rst_err", W'(frame_err), W'(0));
      model_reset();
      @(posedge clk); ecnt++;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 55, 0, 0); cycle(1, 56, 0, 0); cycle(1, 57, 0, 0); cycle(1, 58, 0, 0);
      idle(3);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         p   = $urandom_range(0, 255);
         sof = ($urandom_range(0, 15) == 0);
         eof = ($urandom_range(0, 11) == 0);
         if (exp_q.size() > 0 && exp_q[$].cyc >= ecnt + 1) eof = 0;
         cycle(v, p, sof, eof);
      end
      idle(8);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
